// File: rtl/tdc_stream_rx.sv
// Receive end of the TDC serial link: 8N1 UART deserializer plus 2-byte record
// assembler that decodes line/frame marker records and tracks the line index.
module tdc_stream_rx #(
   parameter int          CLK_PER_BIT  = 12,
   parameter int          TIMEOUT_BITS = 20,
   parameter logic [15:0] LINE_MARK    = 16'hFFFF,
   parameter logic [15:0] FRAME_MARK   = 16'hFFFE
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] sample,
   output logic        new_sample,
   output logic        new_line,
   output logic        new_frame,
   output logic [15:0] line_index,
   output logic        framing_error,
   output logic        sync_lost
);

   localparam int CNT_W     = $clog2(CLK_PER_BIT);
   localparam int GAP_LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
   localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIMIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             half_q, half_d;
   logic [7:0]       hi_byte_q, hi_byte_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [15:0]      sample_q, sample_d;
   logic [15:0]      line_index_q, line_index_d;
   logic             new_sample_q, new_sample_d;
   logic             new_line_q, new_line_d;
   logic             new_frame_q, new_frame_d;
   logic             framing_error_q, framing_error_d;
   logic             sync_lost_q, sync_lost_d;

   logic             start_det;
   logic             byte_ok;
   logic             byte_bad;
   logic [15:0]      record;

   // Previous-sample flop resets low so a line held low through reset is not a start edge.
   assign start_det = rx_prev_q & ~rx_sync_q;
   assign record    = {hi_byte_q, shift_q};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_det) begin
               state_d   = S_START;
               bit_idx_d = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  byte_ok = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  byte_bad = 1'b1;
                  state_d  = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rx_sync_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      half_d          = half_q;
      hi_byte_d       = hi_byte_q;
      gap_d           = gap_q;
      sample_d        = sample_q;
      line_index_d    = line_index_q;
      new_sample_d    = 1'b0;
      new_line_d      = 1'b0;
      new_frame_d     = 1'b0;
      framing_error_d = 1'b0;
      sync_lost_d     = 1'b0;

      if (byte_ok) begin
         if (half_q) begin
            half_d = 1'b0;
            if (record == LINE_MARK) begin
               new_line_d   = 1'b1;
               line_index_d = line_index_q + 16'd1;
            end else if (record == FRAME_MARK) begin
               new_frame_d  = 1'b1;
               line_index_d = '0;
            end else begin
               new_sample_d = 1'b1;
               sample_d     = record;
            end
         end else begin
            half_d    = 1'b1;
            hi_byte_d = shift_q;
         end
      end

      if (byte_bad) begin
         framing_error_d = 1'b1;
         half_d          = 1'b0;
      end

      // Gap timer only runs while a high byte waits for its partner on an idle line.
      if (start_det || !half_q) begin
         gap_d = '0;
      end else if (state_q == S_IDLE) begin
         if (gap_q == GAP_LAST) begin
            gap_d       = '0;
            half_d      = 1'b0;
            sync_lost_d = 1'b1;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q       <= 1'b0;
         rx_sync_q       <= 1'b0;
         rx_prev_q       <= 1'b0;
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         bit_idx_q       <= '0;
         shift_q         <= '0;
         half_q          <= 1'b0;
         hi_byte_q       <= '0;
         gap_q           <= '0;
         sample_q        <= '0;
         line_index_q    <= '0;
         new_sample_q    <= 1'b0;
         new_line_q      <= 1'b0;
         new_frame_q     <= 1'b0;
         framing_error_q <= 1'b0;
         sync_lost_q     <= 1'b0;
      end else begin
         rx_meta_q       <= rx;
         rx_sync_q       <= rx_meta_q;
         rx_prev_q       <= rx_sync_q;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bit_idx_q       <= bit_idx_d;
         shift_q         <= shift_d;
         half_q          <= half_d;
         hi_byte_q       <= hi_byte_d;
         gap_q           <= gap_d;
         sample_q        <= sample_d;
         line_index_q    <= line_index_d;
         new_sample_q    <= new_sample_d;
         new_line_q      <= new_line_d;
         new_frame_q     <= new_frame_d;
         framing_error_q <= framing_error_d;
         sync_lost_q     <= sync_lost_d;
      end
   end

   assign sample        = sample_q;
   assign new_sample    = new_sample_q;
   assign new_line      = new_line_q;
   assign new_frame     = new_frame_q;
   assign line_index    = line_index_q;
   assign framing_error = framing_error_q;
   assign sync_lost     = sync_lost_q;

endmodule

// File: tb/tb_tdc_stream_rx.sv
// Bench for tdc_stream_rx: drives 8N1 bytes and compares the DUT's event stream
// against a byte-level record model.
module tb_tdc_stream_rx;

   localparam int CPB     = 12;
   localparam int TO_BITS = 20;

   localparam logic [2:0] EV_SAMPLE = 3'd0;
   localparam logic [2:0] EV_LINE   = 3'd1;
   localparam logic [2:0] EV_FRAME  = 3'd2;
   localparam logic [2:0] EV_FERR   = 3'd3;
   localparam logic [2:0] EV_SLOST  = 3'd4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] samp;
      logic [15:0] lidx;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [15:0] sample;
   logic        new_sample;
   logic        new_line;
   logic        new_frame;
   logic [15:0] line_index;
   logic        framing_error;
   logic        sync_lost;

   tdc_stream_rx dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .sample        (sample),
      .new_sample    (new_sample),
      .new_line      (new_line),
      .new_frame     (new_frame),
      .line_index    (line_index),
      .framing_error (framing_error),
      .sync_lost     (sync_lost)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_cmp = 0;
   int   n_err = 0;
   int   multi_pulse = 0;
   int   last_stop_cyc = 0;
   int   pulse_cnt;
   ev_t  exp_q[$];
   ev_t  obs_q[$];
   int   obs_cyc[$];

   // Reference model state: record-level view of the link
   logic        m_half = 1'b0;
   logic [7:0]  m_hi = 8'h00;
   logic [15:0] m_line = 16'h0000;
   logic [15:0] m_sample = 16'h0000;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [2:0] kind);
      ev_t e;
      e.kind = kind;
      e.samp = m_sample;
      e.lidx = m_line;
      exp_q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok, input int idle);
      logic [15:0] rec;
      if (!ok) begin
         m_half = 1'b0;
         push_exp(EV_FERR);
      end else if (m_half) begin
         rec    = {m_hi, b};
         m_half = 1'b0;
         if (rec == 16'hFFFF) begin
            m_line = m_line + 16'd1;
            push_exp(EV_LINE);
         end else if (rec == 16'hFFFE) begin
            m_line = 16'h0000;
            push_exp(EV_FRAME);
         end else begin
            m_sample = rec;
            push_exp(EV_SAMPLE);
         end
      end else begin
         m_half = 1'b1;
         m_hi   = b;
      end
      if (m_half && idle >= TO_BITS) begin
         m_half = 1'b0;
         push_exp(EV_SLOST);
      end
   endtask

   task automatic model_reset();
      m_half   = 1'b0;
      m_line   = 16'h0000;
      m_sample = 16'h0000;
   endtask

   always @(negedge clk) begin
      pulse_cnt = int'(new_sample) + int'(new_line) + int'(new_frame);
      if (pulse_cnt > 1) multi_pulse++;
      if (new_sample)    begin obs_q.push_back({EV_SAMPLE, sample, line_index}); obs_cyc.push_back(cyc); end
      if (new_line)      begin obs_q.push_back({EV_LINE,   sample, line_index}); obs_cyc.push_back(cyc); end
      if (new_frame)     begin obs_q.push_back({EV_FRAME,  sample, line_index}); obs_cyc.push_back(cyc); end
      if (framing_error) begin obs_q.push_back({EV_FERR,   sample, line_index}); obs_cyc.push_back(cyc); end
      if (sync_lost)     begin obs_q.push_back({EV_SLOST,  sample, line_index}); obs_cyc.push_back(cyc); end
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle_bits(input int n);
      repeat (n) drive_bit(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok, input int low_clks, input int idle);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      last_stop_cyc = cyc;
      drive_bit(ok);
      if (!ok) begin
         rx = 1'b0;
         repeat (low_clks) @(posedge clk);
         #1;
      end
      idle_bits(idle);
      model_byte(b, ok, idle);
   endtask

   task automatic compare_phase(input string tag);
      int n;
      repeat (CPB * 4) @(posedge clk);
      #1;
      check_val({tag, "_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         $display("%s ev %0d: kind=%0d sample=%h line_index=%h (expected kind=%0d sample=%h line_index=%h)",
                  tag, i, obs_q[i].kind, obs_q[i].samp, obs_q[i].lidx,
                  exp_q[i].kind, exp_q[i].samp, exp_q[i].lidx);
         check_val({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
         check_val({tag, "_sample"}, obs_q[i].samp, exp_q[i].samp);
         check_val({tag, "_line_index"}, obs_q[i].lidx, exp_q[i].lidx);
      end
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int   ab_stop;
      int   d;
      int   sel;
      logic [15:0] rec;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_sample", sample, 16'h0000);
      check_val("rst_line_index", line_index, 16'h0000);
      check_val("rst_new_sample", new_sample, 0);
      check_val("rst_new_line", new_line, 0);
      check_val("rst_new_frame", new_frame, 0);
      check_val("rst_framing_error", framing_error, 0);
      check_val("rst_sync_lost", sync_lost, 0);
      idle_bits(2);

      send_byte(8'h12, 1'b1, 0, 2);
      send_byte(8'h34, 1'b1, 0, 2);
      compare_phase("basic");

      send_byte(8'hFF, 1'b1, 0, 0);
      send_byte(8'hFF, 1'b1, 0, 1);
      send_byte(8'hFF, 1'b1, 0, 0);
      send_byte(8'hFF, 1'b1, 0, 1);
      send_byte(8'hFF, 1'b1, 0, 0);
      send_byte(8'hFE, 1'b1, 0, 2);
      compare_phase("markers");

      send_byte(8'hAB, 1'b1, 0, 25);
      ab_stop = last_stop_cyc;
      send_byte(8'hCD, 1'b1, 0, 0);
      send_byte(8'hEF, 1'b1, 0, 2);
      repeat (CPB * 4) @(posedge clk);
      #1;
      for (int i = 0; i < obs_q.size(); i++) begin
         if (obs_q[i].kind == EV_SLOST) begin
            d = obs_cyc[i] - ab_stop;
            check_val("sync_lost_delay_ok", (d >= 244 && d <= 254), 1);
         end
      end
      compare_phase("timeout");

      send_byte(8'h55, 1'b0, 30, 2);
      send_byte(8'h01, 1'b1, 0, 0);
      send_byte(8'h02, 1'b1, 0, 2);
      compare_phase("framing");

      rx = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rx = 1'b1;
      idle_bits(3);
      send_byte(8'hFF, 1'b1, 0, 0);
      send_byte(8'hFF, 1'b1, 0, 2);
      compare_phase("glitch");

      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      rx  = 1'b0;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      model_reset();
      check_val("midrst_sample", sample, 16'h0000);
      check_val("midrst_line_index", line_index, 16'h0000);
      rx = 1'b1;
      idle_bits(2);
      send_byte(8'h00, 1'b1, 0, 0);
      send_byte(8'h07, 1'b1, 0, 2);
      compare_phase("midreset");

      for (int r = 0; r < 200; r++) begin
         sel = $urandom_range(0, 19);
         if (sel == 0)      rec = 16'hFFFF;
         else if (sel == 1) rec = 16'hFFFE;
         else               rec = 16'($urandom);
         send_byte(rec[15:8], 1'b1, 0, 0);
         send_byte(rec[7:0], 1'b1, 0, $urandom_range(0, 1));
      end
      compare_phase("random");

      check_val("pulse_exclusive", multi_pulse, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
